// File: rtl/out_port_arbiter.sv
// out_port_arbiter: round-robin arbiter of two write requesters into a FIFO feeding one output port
module out_port_arbiter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  input  logic [WIDTH-1:0]           req0_data,
  output logic                       req0_ready,
  input  logic                       req1_valid,
  input  logic [WIDTH-1:0]           req1_data,
  output logic                       req1_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic last_grant, room, push, pop;
  // Grant decision ignores a same-cycle pop so a full buffer never accepts until it has drained
  always_comb begin
    full       = count == (AW+1)'(DEPTH);
    room       = !rst && !full;
    req0_ready = room && req0_valid && (!req1_valid || last_grant);
    req1_ready = room && req1_valid && (!req0_valid || !last_grant);
    push       = req0_ready || req1_ready;
    out_valid  = count != '0;
    pop        = out_valid && out_ready;
    out_data   = out_valid ? mem[rd_ptr] : '0;
  end
  // Storage is left uncleared by reset; emptiness is tracked by count alone
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= req0_ready ? req0_data : req1_data;
  // Pointer, occupancy and round-robin state
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push) last_grant <= req1_ready;
      count <= push && !pop ? count + 1'b1 : !push && pop ? count - 1'b1 : count;
    end
  end
endmodule

// File: tb/tb_out_port_arbiter.sv
// tb_out_port_arbiter: directed and random scoreboard checks of the output-port arbiter
module tb_out_port_arbiter;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, out_ready = 0;
  logic [15:0] req0_data = 0, req1_data = 0, out_data;
  logic req0_ready, req1_ready, out_valid, full;
  logic [2:0] count;
  int tests = 0, fails = 0;
  logic [15:0] sb [$];
  int m_count = 0;
  bit m_last = 1;

  out_port_arbiter #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit v0, input logic [15:0] d0,
                      input bit v1, input logic [15:0] d1, input bit ordy);
    bit room, e0, e1;
    @(negedge clk);
    rst = r; req0_valid = v0; req0_data = d0;
    req1_valid = v1; req1_data = d1; out_ready = ordy;
    #1;
    room = !r && m_count != 4;
    e0 = room && v0 && (!v1 || m_last);
    e1 = room && v1 && (!v0 || !m_last);
    check("req0_ready", {31'b0, req0_ready}, {31'b0, e0});
    check("req1_ready", {31'b0, req1_ready}, {31'b0, e1});
    if (!r) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, m_count != 0});
      check("out_data", {16'b0, out_data}, {16'b0, sb.size() != 0 ? sb[0] : 16'h0});
      check("count", {29'b0, count}, m_count);
      check("full", {31'b0, full}, {31'b0, m_count == 4});
    end
    if (r) begin
      sb.delete(); m_count = 0; m_last = 1;
    end else begin
      if (m_count != 0 && ordy) void'(sb.pop_front());
      if (e0) begin sb.push_back(d0); m_last = 0; end
      if (e1) begin sb.push_back(d1); m_last = 1; end
      m_count = sb.size();
    end
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 16'h00A5, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    repeat (5) step(0, 1, 16'h1111, 1, 16'h2222, 0);
    step(0, 0, 0, 1, 16'h3333, 1);
    step(0, 0, 0, 1, 16'h3333, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 16'h4444, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 1);
    step(0, 1, 16'h0005, 0, 0, 0);
    step(0, 1, 16'h0006, 0, 0, 0);
    step(0, 1, 16'h0007, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 16'hAAAA, 1, 16'hBBBB, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 60; i++)
      step(0, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
           16'($urandom), 1'($urandom_range(0, 2) == 0));
    repeat (5) step(0, 0, 0, 0, 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/out_port_arbiter.md
OUT_PORT_ARBITER -- requirements
Module: out_port_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, setting the data width of every data port.
REQ-002 The block SHALL have parameter DEPTH, default 4, setting the number of buffer entries; DEPTH SHALL be a power of two, 2..16.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-005 The block SHALL have ports req0_valid and req0_data, inputs, 1 and WIDTH bits: pipeline OUT-instruction write request and its data.
REQ-006 The block SHALL have port req0_ready, output, 1 bit: high when req0 is granted this cycle.
REQ-007 The block SHALL have ports req1_valid and req1_data, inputs, 1 and WIDTH bits: secondary requester (status/debug) write request and its data.
REQ-008 The block SHALL have port req1_ready, output, 1 bit: high when req1 is granted this cycle.
REQ-009 The block SHALL have ports out_data and out_valid, outputs, WIDTH and 1 bits: head of buffer presented to the external port.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the external consumer accepts the head this cycle.
REQ-011 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: current buffer occupancy.
REQ-012 The block SHALL have port full, output, 1 bit: high when count == DEPTH.

Function
REQ-013 The block SHALL define a transfer on requester N as reqN_valid & reqN_ready, and a pop as out_valid & out_ready.
REQ-014 The block SHALL grant at most one requester per cycle, and only when count < DEPTH; the grant SHALL NOT depend on a same-cycle pop.
REQ-015 If exactly one requester is valid and count < DEPTH, the block SHALL grant that requester.
REQ-016 If both requesters are valid and count < DEPTH, the block SHALL grant the requester not recorded in last_grant (round-robin).
REQ-017 The block SHALL update last_grant on every transfer, and SHALL hold it when no transfer occurs.
REQ-018 The reqN_ready outputs SHALL be combinational from reqN_valid, count and last_grant; reqN_ready SHALL be low whenever reqN_valid is low.
REQ-019 On a transfer, the block SHALL write the granted data to the entry at wr_ptr and advance wr_ptr modulo DEPTH.
REQ-020 On a pop, the block SHALL advance rd_ptr modulo DEPTH.
REQ-021 The count update SHALL be: +1 on transfer only, -1 on pop only, unchanged on simultaneous transfer and pop or on neither.
REQ-022 The block SHALL drive out_valid = (count != 0), and SHALL drive out_data as the entry at rd_ptr when out_valid is high and 0 otherwise.
REQ-023 Latency SHALL be one cycle: data transferred at edge N into an empty buffer SHALL be visible on out_data, with out_valid high, immediately after edge N.
REQ-024 Occupancy state SHALL be EMPTY (count == 0), PARTIAL (0 < count < DEPTH) or FULL (count == DEPTH); transitions SHALL follow REQ-021 only.
REQ-025 In FULL, both reqN_ready SHALL be low; a pop SHALL move the state to PARTIAL, and grants SHALL resume on the following cycle.
REQ-026 In EMPTY, no pop SHALL occur, since out_valid is low.
REQ-027 out_data SHALL hold stable while out_valid is high and out_ready is low.
REQ-028 The data order presented on out_data SHALL equal the transfer order.

Reset
REQ-029 On posedge clk with rst high, the block SHALL clear wr_ptr, rd_ptr and count, set last_grant = 1 so that req0 wins the first tie, and force out_valid = 0, out_data = 0 and full = 0.
REQ-030 While rst is high, req0_ready and req1_ready SHALL be low and no transfer or pop SHALL take effect.
REQ-031 A reset asserted mid-operation SHALL discard all buffered entries; buffer storage need not be cleared.

Verification
REQ-032 Reset, then req0_valid=1 with data 0x00A5 for one cycle and out_ready=0: req0_ready=1 that cycle; next cycle out_valid=1, out_data=0x00A5, count=1.
REQ-033 After reset, both valid for 4 cycles with req0 data 0x1111 and req1 data 0x2222, out_ready=0: grants req0, req1, req0, req1; full=1; readiness low in the 5th cycle; drain yields 0x1111, 0x2222, 0x1111, 0x2222.
REQ-034 With the buffer full, hold out_ready=1 and req1_valid=1: the pop cycle shows req1_ready=0; the next cycle shows req1_ready=1; count returns to 4.
REQ-035 With count=2, a same-cycle req0 transfer and pop: count stays 2 and order is preserved.
REQ-036 Assert rst with count=3 and out_ready=1: the next cycle shows count=0, out_valid=0, out_data=0; a subsequent tie grants req0.
